// File: rtl/counter_mod8_down.sv
// Mod-8 down counter (HI..LO) with run-control FSM, parallel load and a registered
// one-cycle borrow pulse. Auto-reload or one-shot underflow behaviour selected by mode.
module counter_mod8_down #(
    parameter int WIDTH = 4,
    parameter int HI    = 9,
    parameter int LO    = 2
) (
    input  logic             cp,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    input  logic             mode,
    output logic [WIDTH-1:0] Q,
    output logic             qcb,
    output logic             busy
);

    localparam logic [WIDTH-1:0] HI_V  = WIDTH'(HI);
    localparam logic [WIDTH-1:0] LO_V  = WIDTH'(LO);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_s;
    logic             qcb_r;
    logic             qcb_s;
    logic             busy_r;
    logic             busy_s;

    function automatic logic in_range(input logic [WIDTH-1:0] v);
        in_range = (v >= LO_V) && (v <= HI_V);
    endfunction

    // Next-state, next-count and borrow decode; load takes priority over counting.
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        qcb_s   = 1'b0;
        if (ld) begin
            if (in_range(D)) begin
                q_s = D;
            end else begin
                q_s = HI_V;
            end
            if (state_r == ST_DONE) begin
                state_s = ST_IDLE;
            end else begin
                state_s = state_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Start latency: entering RUN does not decrement on the same edge.
                    if (en) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        q_s = q_r;
                    end else if (!in_range(q_r)) begin
                        q_s = HI_V;
                    end else if (q_r == LO_V) begin
                        qcb_s = 1'b1;
                        if (mode) begin
                            q_s     = LO_V;
                            state_s = ST_DONE;
                        end else begin
                            q_s     = HI_V;
                            state_s = ST_RUN;
                        end
                    end else begin
                        q_s = q_r - ONE_V;
                    end
                end
                ST_DONE: begin
                    // Stay parked until en drops, so a held run request cannot re-trigger.
                    if (en) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_IDLE;
                        q_s     = HI_V;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    q_s     = HI_V;
                end
            endcase
        end
        busy_s = (state_s == ST_RUN);
    end

    // State, count, borrow and busy registers with synchronous clear.
    always_ff @(posedge cp) begin
        if (clr) begin
            state_r <= ST_IDLE;
            q_r     <= HI_V;
            qcb_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            qcb_r   <= qcb_s;
            busy_r  <= busy_s;
        end
    end

    assign Q    = q_r;
    assign qcb  = qcb_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_counter_mod8_down.sv
// Directed bench for counter_mod8_down: reset, auto-reload, one-shot, pause/load,
// simultaneous events and mode sampling at the terminal edge.
module tb_counter_mod8_down;

    logic       cp;
    logic       clr;
    logic       en;
    logic       ld;
    logic [3:0] D;
    logic       mode;
    logic [3:0] Q;
    logic       qcb;
    logic       busy;

    int checks_cnt;
    int errors_cnt;

    counter_mod8_down #(.WIDTH(4), .HI(9), .LO(2)) dut (
        .cp   (cp),
        .clr  (clr),
        .en   (en),
        .ld   (ld),
        .D    (D),
        .mode (mode),
        .Q    (Q),
        .qcb  (qcb),
        .busy (busy)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic expect_out(input string tag, input int eq, input int eqcb, input int ebusy);
        check_val({tag, ".Q"}, 32'(Q), 32'(eq));
        check_val({tag, ".qcb"}, 32'(qcb), 32'(eqcb));
        check_val({tag, ".busy"}, 32'(busy), 32'(ebusy));
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        clr  = 1'b1;
        en   = 1'b0;
        ld   = 1'b0;
        D    = 4'd0;
        mode = 1'b0;

        step();
        step();
        expect_out("reset", 9, 0, 0);
        clr = 1'b0;
        step();
        expect_out("idle_hold", 9, 0, 0);

        // Auto-reload with en held high.
        en = 1'b1;
        step();
        expect_out("start", 9, 0, 1);
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i <= 7; i++) begin
                step();
                expect_out($sformatf("auto_p%0d_%0d", p, i), 9 - i, 0, 1);
            end
            step();
            expect_out($sformatf("auto_borrow%0d", p), 9, 1, 1);
        end

        // One-shot from a loaded value.
        en  = 1'b0;
        clr = 1'b1;
        step();
        clr  = 1'b0;
        mode = 1'b1;
        ld   = 1'b1;
        D    = 4'd4;
        step();
        expect_out("os_load", 4, 0, 0);
        ld = 1'b0;
        en = 1'b1;
        step();
        expect_out("os_start", 4, 0, 1);
        step();
        expect_out("os_3", 3, 0, 1);
        step();
        expect_out("os_2", 2, 0, 1);
        step();
        expect_out("os_borrow", 2, 1, 0);
        step();
        expect_out("os_done_hold", 2, 0, 0);
        en = 1'b0;
        step();
        expect_out("os_to_idle", 9, 0, 0);

        // Pause and load during RUN.
        en = 1'b1;
        step();
        expect_out("p_start", 9, 0, 1);
        step();
        step();
        step();
        expect_out("p_at6", 6, 0, 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("pause%0d", i), 6, 0, 1);
        end
        ld = 1'b1;
        D  = 4'd12;
        step();
        expect_out("ld_clamp_hi", 9, 0, 1);
        D = 4'd1;
        step();
        expect_out("ld_clamp_lo", 9, 0, 1);
        D  = 4'd5;
        en = 1'b1;
        step();
        expect_out("ld_with_en", 5, 0, 1);
        ld = 1'b0;
        step();
        expect_out("after_ld_4", 4, 0, 1);
        step();
        step();
        expect_out("at_lo", 2, 0, 1);

        // clr together with en at LO: no borrow.
        clr = 1'b1;
        step();
        expect_out("clr_at_lo", 9, 0, 0);
        clr  = 1'b0;
        mode = 1'b0;
        step();
        expect_out("restart", 9, 0, 1);
        ld = 1'b1;
        D  = 4'd2;
        step();
        expect_out("ld_to_lo", 2, 0, 1);
        D = 4'd7;
        step();
        expect_out("ld_at_lo", 7, 0, 1);
        ld = 1'b0;

        // Mode changes before the LO edge have no effect; value at that edge wins.
        mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_out($sformatf("mode_cnt%0d", i), 7 - i, 0, 1);
        end
        mode = 1'b0;
        step();
        expect_out("mode_lo_edge", 9, 1, 1);

        // Load while DONE returns to IDLE.
        ld = 1'b1;
        D  = 4'd3;
        step();
        expect_out("ld3", 3, 0, 1);
        ld   = 1'b0;
        mode = 1'b1;
        step();
        expect_out("os2_2", 2, 0, 1);
        step();
        expect_out("os2_borrow", 2, 1, 0);
        ld = 1'b1;
        D  = 4'd6;
        step();
        expect_out("ld_in_done", 6, 0, 0);
        ld = 1'b0;
        step();
        expect_out("idle_to_run", 6, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
